freq_meas_scheduler: RTL
========================

# freq_meas_scheduler

Controller that sequences the frequency-measurement datapath across several Superchip output pins. On a start command it walks the enabled channels in ascending order. For each channel it:
- drives the input-mux select,
- waits for the mux to settle,
- enables the measurement unit with the configured sample count,
- captures the 16-bit result or a timeout,
- presents the result on a valid/ready port.

It sits between the host command interface and the single shared `freq_measurement` instance.

## Interface
Parameters:
- `N_CH`, 4, number of measurable input channels (≥2)
- `SETTLE_CYC`, 4, cycles between mux change and `meas_enable` rising
- `GAP_CYC`, 2, minimum cycles `meas_enable` is held low between measurements
- `TIMEOUT_W`, 20, width of the timeout counter

Ports (`CH_W = $clog2(N_CH)`):
- `Clock` in 1: single clock, rising edge.
- `Reset` in 1: synchronous, active-high.
- `start` in 1: begin scan; sampled only in IDLE.
- `abort` in 1: terminate scan; any state returns to IDLE next cycle.
- `channel_mask` in N_CH: channels to measure; captured at start.
- `samples_cfg` in 8: samples per measurement; captured at start; 0 is treated as 1.
- `timeout_cfg` in TIMEOUT_W: max cycles in MEASURE; captured at start; 0 means no timeout.
- `ch_sel` out CH_W: input-mux select.
- `meas_enable` out 1: enable to the measurement unit.
- `meas_samples` out 8: samples_required to the measurement unit.
- `meas_value` in 16: out_value from the measurement unit.
- `meas_done` in 1: done_flag from the measurement unit.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_channel` out CH_W: channel of the current result.
- `res_value` out 16: measured count; 0 on timeout.
- `res_timeout` out 1: result is a timeout.
- `busy` out 1: high in any state other than IDLE.
- `scan_done` out 1: one-cycle pulse at the end of a scan.

## Operation
States: IDLE, SELECT, SETTLE, MEASURE, PRESENT, GAP.

- **IDLE**
  - `start`=1 captures the configuration.
  - If `channel_mask`==0: `scan_done` pulses the next cycle and the FSM stays in IDLE.
  - Otherwise `ch_sel` is set to the lowest set bit and the FSM enters SELECT.
- **SELECT**: lasts 1 cycle. It loads the settle counter, then goes to SETTLE.
- **SETTLE**: counts SETTLE_CYC cycles with `meas_enable`=0, then goes to MEASURE.
- **MEASURE**
  - `meas_enable`=1.
  - The timeout counter runs from 0.
  - `meas_done`=1: `meas_value` is registered into `res_value`, `res_timeout`=0, then PRESENT.
  - Counter reaches `timeout_cfg` (nonzero) first: `res_value`=0, `res_timeout`=1, then PRESENT.
  - If `meas_done` and timeout occur on the same cycle, done wins.
- **PRESENT**
  - `meas_enable`=0 and `res_valid`=1.
  - `res_*` outputs are held stable until `res_valid`&&`res_ready`, then GAP.
- **GAP**
  - Lasts GAP_CYC cycles with `meas_enable`=0.
  - If more channels remain: `ch_sel` advances to the next set bit above the current one, then SELECT.
  - If none remain: `scan_done` pulses and the FSM enters IDLE.
- `meas_done` is ignored outside MEASURE.
- `start` is ignored while `busy`.
- `abort` has priority over every transition except `Reset`. On abort:
  - next cycle: IDLE, `meas_enable`=0, `res_valid`=0;
  - no `scan_done` pulse;
  - a pending result is discarded.
- `meas_samples` is driven from the captured `samples_cfg` throughout the scan.

## Timing
- Reset values: `ch_sel`=0, `meas_enable`=0, `meas_samples`=0, `res_valid`=0, `res_channel`=0, `res_value`=0, `res_timeout`=0, `busy`=0, `scan_done`=0. State is IDLE.
- `Reset` in the middle of an operation behaves identically to power-up reset on the next edge.
- Outputs `meas_enable`, `ch_sel` and `res_*` are all registered.
- `start` sampled at edge t:
  - t+1: SELECT, `busy`=1;
  - t+2 … t+1+SETTLE_CYC: SETTLE;
  - t+2+SETTLE_CYC: `meas_enable` rises.
- `meas_done` sampled at edge d: `res_valid`=1 at d+1, and `meas_enable`=0 at d+1.
- Handshake at edge h: `res_valid`=0 at h+1. The next channel's `meas_enable` rises at h+1+GAP_CYC+1+SETTLE_CYC.
- `scan_done` occurs at h+GAP_CYC+1 after the last handshake, and `busy`=0 in the same cycle.
- Timeout counter is TIMEOUT_W bits and saturates; it is compared with `timeout_cfg` using `>=`.

## Structure
- Package `freq_pkg`:
  - state enum `sched_state_t`;
  - constants `COUNT_W`=16 and `SAMPLE_W`=8, shared with the measurement unit.
- Sub-module `freq_meas_timer`: a loadable down/up cycle counter with a terminal flag. It is instantiated once and reused for the settle, gap and timeout intervals, since only one interval is active at a time.
- A next-set-bit priority encoder over the captured mask, implemented as a function in the package.

## Test plan
- **Single channel:** mask=4'b0001, `samples_cfg`=22, `timeout_cfg`=0, unit model returns 16'd1000 with done 200 cycles after enable. Required: one result with channel 0, value 1000, `res_timeout`=0, then `scan_done` one pulse.
- **Sparse mask with back-to-back ready:** mask=4'b1010. Required: results in order for ch1 then ch3, `meas_enable` low ≥GAP_CYC+1+SETTLE_CYC cycles between measurements, `ch_sel` changes only while enable is low.
- **Timeout:** `timeout_cfg`=500, unit never asserts done. Required: `res_valid` 501 cycles after enable rises, value 0, `res_timeout`=1, and the scan continues.
- **Backpressure:** `res_ready` held low for 10 cycles while `res_valid`. Required: `res_*` stable, `meas_enable`=0, no advance until the handshake.
- **Zero mask and ignored inputs:** start with mask=0 gives `scan_done` at t+1 with `busy` never high. A second `start` during a scan is ignored. A `meas_done` pulse in SETTLE is ignored.
- **Abort and reset mid-scan:** abort in MEASURE gives IDLE next cycle, all outputs at reset values, no `scan_done`. Synchronous `Reset` during PRESENT gives the same result.

Source files
------------

// File: rtl/freq_pkg.sv
// Shared types and helpers for the frequency-measurement scheduler and its
// measurement unit.
package freq_pkg;

  localparam int unsigned COUNT_W  = 16;
  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned MAX_CH   = 32;
  localparam int unsigned MAX_CH_W = 5;
  localparam int unsigned FROM_W   = MAX_CH_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_MEASURE = 3'd3,
    ST_PRESENT = 3'd4,
    ST_GAP     = 3'd5
  } sched_state_t;

  typedef struct packed {
    logic                found;
    logic [MAX_CH_W-1:0] idx;
  } next_bit_t;

  // Lowest set bit of mask at or above position 'from'.
  function automatic next_bit_t next_set_bit(input logic [MAX_CH-1:0] mask,
                                             input logic [FROM_W-1:0] from);
    next_bit_t r;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        r.found = 1'b1;
        r.idx   = MAX_CH_W'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/freq_meas_timer.sv
// Loadable cycle counter: counts down to zero (terminal flag) or counts up
// with saturation, shared by the settle, gap and timeout intervals.
module freq_meas_timer #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count_up,
  output logic [W-1:0] count,
  output logic         term
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load, saturating up-count, or down-count stopping at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (count_up) begin
      if (cnt_q != {W{1'b1}}) begin
        cnt_d = cnt_q + ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign term  = (cnt_q == '0);

endmodule

// File: rtl/freq_meas_scheduler.sv
// Walks the enabled channels, sequencing mux select, settle, measurement,
// result handshake and inter-measurement gap around one shared measurement unit.
module freq_meas_scheduler
  import freq_pkg::*;
#(
  parameter  int unsigned N_CH       = 4,
  parameter  int unsigned SETTLE_CYC = 4,
  parameter  int unsigned GAP_CYC    = 2,
  parameter  int unsigned TIMEOUT_W  = 20,
  localparam int unsigned CH_W       = $clog2(N_CH)
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [N_CH-1:0]      channel_mask,
  input  logic [SAMPLE_W-1:0]  samples_cfg,
  input  logic [TIMEOUT_W-1:0] timeout_cfg,
  output logic [CH_W-1:0]      ch_sel,
  output logic                 meas_enable,
  output logic [SAMPLE_W-1:0]  meas_samples,
  input  logic [COUNT_W-1:0]   meas_value,
  input  logic                 meas_done,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CH_W-1:0]      res_channel,
  output logic [COUNT_W-1:0]   res_value,
  output logic                 res_timeout,
  output logic                 busy,
  output logic                 scan_done
);

  localparam logic [TIMEOUT_W-1:0] SETTLE_LOAD = TIMEOUT_W'(SETTLE_CYC - 1);
  localparam logic [TIMEOUT_W-1:0] GAP_LOAD    = TIMEOUT_W'(GAP_CYC - 1);

  sched_state_t         state_q, state_d;
  logic [CH_W-1:0]      ch_sel_q, ch_sel_d;
  logic                 meas_enable_q, meas_enable_d;
  logic [SAMPLE_W-1:0]  meas_samples_q, meas_samples_d;
  logic [N_CH-1:0]      mask_q, mask_d;
  logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
  logic                 res_valid_q, res_valid_d;
  logic [CH_W-1:0]      res_channel_q, res_channel_d;
  logic [COUNT_W-1:0]   res_value_q, res_value_d;
  logic                 res_timeout_q, res_timeout_d;
  logic                 busy_q, busy_d;
  logic                 scan_done_q, scan_done_d;

  logic                 tmr_load_s;
  logic [TIMEOUT_W-1:0] tmr_val_s;
  logic                 tmr_up_s;
  logic [TIMEOUT_W-1:0] tmr_cnt_s;
  logic                 tmr_term_s;
  logic                 timed_out_s;
  next_bit_t            first_s;
  next_bit_t            next_s;
  logic [MAX_CH_W-1:0]  first_idx_s;
  logic [MAX_CH_W-1:0]  next_idx_s;

  assign tmr_up_s    = (state_q == ST_MEASURE);
  assign timed_out_s = (timeout_q != '0) && (tmr_cnt_s >= timeout_q);

  freq_meas_timer #(
    .W (TIMEOUT_W)
  ) u_timer (
    .clk      (Clock),
    .rst      (Reset),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .count_up (tmr_up_s),
    .count    (tmr_cnt_s),
    .term     (tmr_term_s)
  );

  // Channel search: first channel of a fresh mask, next channel above current.
  always_comb begin
    first_s     = next_set_bit(MAX_CH'(channel_mask), '0);
    next_s      = next_set_bit(MAX_CH'(mask_q), FROM_W'(ch_sel_q) + FROM_W'(1));
    first_idx_s = first_s.idx;
    next_idx_s  = next_s.idx;
  end

  // Scheduler next-state and registered-output logic; abort overrides all.
  always_comb begin
    state_d        = state_q;
    ch_sel_d       = ch_sel_q;
    meas_samples_d = meas_samples_q;
    mask_d         = mask_q;
    timeout_d      = timeout_q;
    res_valid_d    = res_valid_q;
    res_channel_d  = res_channel_q;
    res_value_d    = res_value_q;
    res_timeout_d  = res_timeout_q;
    scan_done_d    = 1'b0;
    tmr_load_s     = 1'b0;
    tmr_val_s      = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d         = channel_mask;
          timeout_d      = timeout_cfg;
          meas_samples_d = (samples_cfg == 8'd0) ? 8'd1 : samples_cfg;
          if (channel_mask == '0) begin
            scan_done_d = 1'b1;
          end else begin
            ch_sel_d = first_idx_s[CH_W-1:0];
            state_d  = ST_SELECT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SELECT: begin
        tmr_load_s = 1'b1;
        tmr_val_s  = SETTLE_LOAD;
        state_d    = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (tmr_term_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = '0;
          state_d    = ST_MEASURE;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_MEASURE: begin
        // A done on the timeout cycle still reports the measured value.
        if (meas_done) begin
          res_value_d   = meas_value;
          res_timeout_d = 1'b0;
          res_channel_d = ch_sel_q;
          res_valid_d   = 1'b1;
          state_d       = ST_PRESENT;
        end else if (timed_out_s) begin
          res_value_d   = '0;
          res_timeout_d = 1'b1;
          res_channel_d = ch_sel_q;
          res_valid_d   = 1'b1;
          state_d       = ST_PRESENT;
        end else begin
          state_d = ST_MEASURE;
        end
      end
      ST_PRESENT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          tmr_load_s  = 1'b1;
          tmr_val_s   = GAP_LOAD;
          state_d     = ST_GAP;
        end else begin
          state_d = ST_PRESENT;
        end
      end
      ST_GAP: begin
        if (!tmr_term_s) begin
          state_d = ST_GAP;
        end else if (next_s.found) begin
          ch_sel_d = next_idx_s[CH_W-1:0];
          state_d  = ST_SELECT;
        end else begin
          scan_done_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_d        = ST_IDLE;
      ch_sel_d       = '0;
      meas_samples_d = '0;
      mask_d         = '0;
      timeout_d      = '0;
      res_valid_d    = 1'b0;
      res_channel_d  = '0;
      res_value_d    = '0;
      res_timeout_d  = 1'b0;
      scan_done_d    = 1'b0;
    end else begin
      state_d = state_d;
    end

    meas_enable_d = (state_d == ST_MEASURE);
    busy_d        = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q        <= ST_IDLE;
      ch_sel_q       <= '0;
      meas_enable_q  <= 1'b0;
      meas_samples_q <= '0;
      mask_q         <= '0;
      timeout_q      <= '0;
      res_valid_q    <= 1'b0;
      res_channel_q  <= '0;
      res_value_q    <= '0;
      res_timeout_q  <= 1'b0;
      busy_q         <= 1'b0;
      scan_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      ch_sel_q       <= ch_sel_d;
      meas_enable_q  <= meas_enable_d;
      meas_samples_q <= meas_samples_d;
      mask_q         <= mask_d;
      timeout_q      <= timeout_d;
      res_valid_q    <= res_valid_d;
      res_channel_q  <= res_channel_d;
      res_value_q    <= res_value_d;
      res_timeout_q  <= res_timeout_d;
      busy_q         <= busy_d;
      scan_done_q    <= scan_done_d;
    end
  end

  assign ch_sel       = ch_sel_q;
  assign meas_enable  = meas_enable_q;
  assign meas_samples = meas_samples_q;
  assign res_valid    = res_valid_q;
  assign res_channel  = res_channel_q;
  assign res_value    = res_value_q;
  assign res_timeout  = res_timeout_q;
  assign busy         = busy_q;
  assign scan_done    = scan_done_q;

endmodule
